// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction fetch stage. Owns the program counter, reads a word-indexed
// instruction memory with one-cycle latency and hands {instr, pc, fault}
// entries to decode through a small valid/ready prefetch queue.
// Supports redirect/flush, back-pressure, alignment/range faults and a
// memory load port.
module fetch_unit #(
  parameter int              XLEN       = 32,
  parameter int              MEM_DEPTH  = 64,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC   = {XLEN{1'b0}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         imem_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] imem_addr,
  input  logic [XLEN-1:0]              imem_wdata,
  input  logic                         redirect_valid,
  input  logic [XLEN-1:0]              redirect_pc,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [XLEN-1:0]              out_instr,
  output logic [XLEN-1:0]              out_pc,
  output logic                         out_fault
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = CW + 1;

  localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(32'd4);
  localparam logic [XLEN-1:0] MEM_WORDS = XLEN'(MEM_DEPTH);
  localparam logic [PW-1:0]   LAST_PTR  = PW'(FIFO_DEPTH - 1);
  localparam logic [OW-1:0]   DEPTH_OCC = OW'(FIFO_DEPTH);

  // A fetch address is unusable if it is not word-aligned or lies past the
  // last memory word.
  function automatic logic pc_fault_f(input logic [XLEN-1:0] pc);
    logic misaligned_s;
    logic out_of_range_s;
    misaligned_s   = (pc[1:0] != 2'b00);
    out_of_range_s = ((pc >> 2) >= MEM_WORDS);
    return misaligned_s | out_of_range_s;
  endfunction

  // Circular pointer advance; the queue depth need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc_f(input logic [PW-1:0] ptr);
    logic [PW-1:0] nxt_s;
    if (ptr == LAST_PTR) begin
      nxt_s = {PW{1'b0}};
    end else begin
      nxt_s = ptr + PW'(1);
    end
    return nxt_s;
  endfunction

  // Program counter and halt flag
  logic [XLEN-1:0] pc_r;
  logic            halted_r;

  // Single in-flight read slot; the instruction word itself lands in rdata_r
  logic            infl_valid_r;
  logic [XLEN-1:0] infl_pc_r;
  logic            infl_fault_r;
  logic [XLEN-1:0] rdata_r;

  // Instruction memory (contents survive reset)
  logic [XLEN-1:0] mem_r [0:MEM_DEPTH-1];

  // Prefetch queue
  logic [XLEN-1:0] fifo_instr_r [0:FIFO_DEPTH-1];
  logic [XLEN-1:0] fifo_pc_r    [0:FIFO_DEPTH-1];
  logic            fifo_fault_r [0:FIFO_DEPTH-1];
  logic [PW-1:0]   rd_ptr_r;
  logic [PW-1:0]   wr_ptr_r;
  logic [CW-1:0]   count_r;

  // Combinational control
  logic            head_valid_s;
  logic            pop_raw_s;
  logic            pop_s;
  logic            push_s;
  logic [OW-1:0]   occ_s;
  logic            issue_s;
  logic            issue_fault_s;
  logic [AW-1:0]   rd_idx_s;
  logic [XLEN-1:0] push_instr_s;

  // Queue handshake, occupancy look-ahead and the issue decision. The
  // look-ahead counts the in-flight read as already occupying a slot, so
  // the queue can never overflow. A redirect discards same-cycle pop/push.
  always_comb begin
    head_valid_s  = (count_r != {CW{1'b0}});
    pop_raw_s     = head_valid_s & out_ready;
    pop_s         = pop_raw_s & ~redirect_valid;
    push_s        = infl_valid_r & ~redirect_valid;
    occ_s         = OW'(count_r) + OW'(infl_valid_r) - OW'(pop_raw_s);
    issue_fault_s = pc_fault_f(pc_r);
    rd_idx_s      = pc_r[2 +: AW];
    if (rst || redirect_valid || halted_r) begin
      issue_s = 1'b0;
    end else begin
      issue_s = (occ_s < DEPTH_OCC);
    end
    if (infl_fault_r) begin
      push_instr_s = NOP_INSTR;
    end else begin
      push_instr_s = rdata_r;
    end
  end

  // Decode-facing view of the queue head; all fields zero when empty.
  always_comb begin
    out_valid = head_valid_s;
    if (head_valid_s) begin
      out_instr = fifo_instr_r[rd_ptr_r];
      out_pc    = fifo_pc_r[rd_ptr_r];
      out_fault = fifo_fault_r[rd_ptr_r];
    end else begin
      out_instr = {XLEN{1'b0}};
      out_pc    = {XLEN{1'b0}};
      out_fault = 1'b0;
    end
  end

  // PC advance on issue, reload on redirect; a faulting issue halts fetch
  // until the next redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else if (redirect_valid) begin
      pc_r     <= redirect_pc;
      halted_r <= 1'b0;
    end else if (issue_s) begin
      pc_r     <= pc_r + PC_STEP;
      halted_r <= issue_fault_s;
    end else begin
      pc_r     <= pc_r;
      halted_r <= halted_r;
    end
  end

  // In-flight slot tracks the read issued last cycle.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      infl_valid_r <= 1'b0;
      infl_pc_r    <= {XLEN{1'b0}};
      infl_fault_r <= 1'b0;
    end else begin
      infl_valid_r <= issue_s;
      if (issue_s) begin
        infl_pc_r    <= pc_r;
        infl_fault_r <= issue_fault_s;
      end else begin
        infl_pc_r    <= infl_pc_r;
        infl_fault_r <= infl_fault_r;
      end
    end
  end

  // Memory load port and registered read; a same-cycle write to the read
  // index is seen only by later reads.
  always_ff @(posedge clk) begin
    if (imem_we) begin
      mem_r[imem_addr] <= imem_wdata;
    end
    if (issue_s) begin
      rdata_r <= mem_r[rd_idx_s];
    end
  end

  // Queue storage: the completed read is written at the tail.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_instr_r[i] <= {XLEN{1'b0}};
        fifo_pc_r[i]    <= {XLEN{1'b0}};
        fifo_fault_r[i] <= 1'b0;
      end
    end else if (push_s) begin
      fifo_instr_r[wr_ptr_r] <= push_instr_s;
      fifo_pc_r[wr_ptr_r]    <= infl_pc_r;
      fifo_fault_r[wr_ptr_r] <= infl_fault_r;
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (pop_s) begin
        rd_ptr_r <= ptr_inc_f(rd_ptr_r);
      end
      if (push_s) begin
        wr_ptr_r <= ptr_inc_f(wr_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed scenarios with literal expectations, then a randomized phase.
// A queue-based behavioural model tracks what decode must see each cycle.
module tb_fetch_unit;

  localparam int          XLEN       = 32;
  localparam int          MEM_DEPTH  = 64;
  localparam int          FIFO_DEPTH = 2;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [31:0] W62        = 32'hCAFE_0062;
  localparam logic [31:0] W63        = 32'hCAFE_0063;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_we = 1'b0;
  logic [5:0]  imem_addr = 6'd0;
  logic [31:0] imem_wdata = 32'd0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  always #5 clk = ~clk;

  fetch_unit #(
    .XLEN(XLEN), .MEM_DEPTH(MEM_DEPTH), .FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_fault(out_fault)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } ent_t;

  // Behavioural model state
  ent_t        m_q[$];
  logic        m_infl_v = 1'b0;
  ent_t        m_infl;
  logic [31:0] m_pc = 32'd0;
  logic        m_halted = 1'b0;
  logic [31:0] m_mem [0:MEM_DEPTH-1];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // One clock of the fetch stage described as queue operations.
  task automatic model_step();
    int   occ;
    bit   pop;
    bit   issue;
    ent_t e;
    if (rst) begin
      m_q.delete();
      m_infl_v = 1'b0;
      m_pc     = RESET_PC;
      m_halted = 1'b0;
    end else if (redirect_valid) begin
      m_q.delete();
      m_infl_v = 1'b0;
      m_halted = 1'b0;
      m_pc     = redirect_pc;
    end else begin
      pop   = (m_q.size() != 0) && out_ready;
      occ   = m_q.size() - int'(pop) + int'(m_infl_v);
      issue = !m_halted && (occ < FIFO_DEPTH);
      if (pop) void'(m_q.pop_front());
      if (m_infl_v) m_q.push_back(m_infl);
      m_infl_v = issue;
      if (issue) begin
        e.pc    = m_pc;
        e.fault = ((m_pc % 4) != 0) || ((m_pc / 4) >= MEM_DEPTH);
        e.instr = e.fault ? NOP : m_mem[(m_pc / 4) % MEM_DEPTH];
        m_infl  = e;
        if (e.fault) m_halted = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end
    if (imem_we) m_mem[imem_addr] = imem_wdata;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare the DUT head against the model every cycle.
  initial forever begin
    ent_t h;
    logic v;
    @(negedge clk);
    if (chk_en) begin
      if (m_q.size() != 0) begin
        v = 1'b1;
        h = m_q[0];
      end else begin
        v = 1'b0;
        h = '0;
      end
      chk("model_valid", {31'd0, out_valid}, {31'd0, v});
      chk("model_instr", out_instr, h.instr);
      chk("model_pc",    out_pc,    h.pc);
      chk("model_fault", {31'd0, out_fault}, {31'd0, h.fault});
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic expect_head(input string tag, input logic v, input logic [31:0] ins,
                             input logic [31:0] pc, input logic f);
    chk({tag, "_valid"}, {31'd0, out_valid}, {31'd0, v});
    chk({tag, "_instr"}, out_instr, ins);
    chk({tag, "_pc"},    out_pc,    pc);
    chk({tag, "_fault"}, {31'd0, out_fault}, {31'd0, f});
  endtask

  task automatic do_redirect(input logic [31:0] target, input logic rdy);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    out_ready      = rdy;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    int          r;

    // Load memory while held in reset
    for (int i = 0; i < MEM_DEPTH; i++) begin
      tick();
      chk_en = 1'b1;
      if (i < 4)        w = 32'h11 * (i + 1);
      else if (i == 62) w = W62;
      else if (i == 63) w = W63;
      else              w = $urandom;
      imem_we    = 1'b1;
      imem_addr  = 6'(i);
      imem_wdata = w;
    end
    tick();
    imem_we = 1'b0;
    expect_head("reset", 1'b0, 32'h0, 32'h0, 1'b0);

    // Start-up latency and streaming
    rst = 1'b0;
    out_ready = 1'b1;
    tick(); expect_head("lat_c1", 1'b0, 32'h0, 32'h0, 1'b0);
    tick(); expect_head("lat_c2", 1'b1, 32'h11, 32'h0, 1'b0);
    tick(); expect_head("str_1", 1'b1, 32'h22, 32'h4, 1'b0);
    tick(); expect_head("str_2", 1'b1, 32'h33, 32'h8, 1'b0);
    tick(); expect_head("str_3", 1'b1, 32'h44, 32'hC, 1'b0);

    // Back-pressure: head held, then drain without loss or duplication
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (10) tick();
    expect_head("bp_hold", 1'b1, 32'h11, 32'h0, 1'b0);
    out_ready = 1'b1;
    tick(); expect_head("bp_rel1", 1'b1, 32'h22, 32'h4, 1'b0);
    tick(); expect_head("bp_rel2", 1'b1, 32'h33, 32'h8, 1'b0);
    tick(); expect_head("bp_rel3", 1'b1, 32'h44, 32'hC, 1'b0);

    // Redirect while the queue is full with a same-cycle pop
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    do_redirect(32'h8, 1'b1);
    expect_head("rd_r1", 1'b0, 32'h0, 32'h0, 1'b0);
    tick(); expect_head("rd_r2", 1'b0, 32'h0, 32'h0, 1'b0);
    tick(); expect_head("rd_r3", 1'b1, 32'h33, 32'h8, 1'b0);

    // Misaligned redirect: one fault entry, then silence until redirect
    do_redirect(32'h6, 1'b0);
    tick();
    tick(); expect_head("mis_fault", 1'b1, NOP, 32'h6, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_head("mis_halt", 1'b0, 32'h0, 32'h0, 1'b0);
    end
    do_redirect(32'h0, 1'b1);
    tick();
    tick(); expect_head("mis_resume", 1'b1, 32'h11, 32'h0, 1'b0);

    // Run off the end of memory
    do_redirect(32'hF8, 1'b1);
    tick();
    tick(); expect_head("end_62", 1'b1, W62, 32'hF8, 1'b0);
    tick(); expect_head("end_63", 1'b1, W63, 32'hFC, 1'b0);
    tick(); expect_head("end_oor", 1'b1, NOP, 32'h100, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_head("end_halt", 1'b0, 32'h0, 32'h0, 1'b0);
    end

    // Reset mid-operation with one queued entry and a read in flight
    do_redirect(32'h0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick(); expect_head("mrst_1", 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    out_ready = 1'b1;
    tick(); expect_head("mrst_2", 1'b0, 32'h0, 32'h0, 1'b0);
    tick(); expect_head("mrst_3", 1'b1, 32'h11, 32'h0, 1'b0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rst            = ($urandom_range(0, 199) == 0);
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 24) == 0);
      r = $urandom_range(0, 19);
      if (r == 0)      redirect_pc = 32'($urandom_range(0, 255)) | 32'h1;
      else if (r == 1) redirect_pc = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      else if (r < 6)  redirect_pc = 32'($urandom_range(0, 63)) << 2;
      else             redirect_pc = 32'($urandom_range(0, 15)) << 2;
      imem_we    = ($urandom_range(0, 9) == 0);
      imem_addr  = 6'($urandom_range(0, 15));
      imem_wdata = $urandom;
      tick();
    end
    rst = 1'b0;
    redirect_valid = 1'b0;
    imem_we = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
